// File: rtl/cpu_mul_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mul_pkg
// Shared definitions for the HI/LO multiply controller and its neighbours in
// the CPU datapath: operand/product widths, settle-counter width, FSM state
// type, and the signed-overflow helper used when the product is captured.
// ---------------------------------------------------------------------------
package cpu_mul_pkg;

    localparam int DATA_W = 32;
    localparam int PROD_W = 64;
    localparam int CNT_W  = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } mul_state_e;

    // A 64-bit product fits in 32 signed bits only when the upper word is the
    // sign-extension of bit 31 of the lower word.
    function automatic logic prod_ovf(input logic [PROD_W-1:0] prod);
        return (prod[PROD_W-1:DATA_W] != {DATA_W{prod[DATA_W-1]}});
    endfunction

endpackage : cpu_mul_pkg

// File: rtl/mul_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// mul_hilo_ctrl
// Sequences an external combinational multiplier and owns the HI/LO result
// registers. On start (in IDLE) the operands are latched onto mul_q/mul_m,
// the product is given SETTLE_CYCLES edges to settle, then captured into
// HI/LO together with a one-cycle done pulse. HI/LO can also be written from
// the bus while idle.
//
// Optional feature: define MUL_HILO_OVF_EN to add the ovf output, which flags
// a captured product that does not fit in 32 signed bits.
//
// Ports
//   clock          : rising-edge clock
//   clear          : asynchronous active-low reset
//   start          : multiply request, sampled in IDLE only
//   op_a, op_b     : signed operands
//   mul_q, mul_m   : latched operands driven to the external multiplier
//   mul_product    : multiplier result, bits [63:0] used, bit 64 ignored
//   hilo_wr_data   : bus write data for HI/LO
//   hi_wr_en       : bus write strobe for HI
//   lo_wr_en       : bus write strobe for LO
//   hi_out, lo_out : HI/LO register contents
//   ovf            : product overflow flag (MUL_HILO_OVF_EN only)
//   busy           : operation in flight
//   done           : one-cycle completion pulse
// ---------------------------------------------------------------------------
module mul_hilo_ctrl
    import cpu_mul_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    output logic [DATA_W-1:0]   mul_q,
    output logic [DATA_W-1:0]   mul_m,
    input  logic [PROD_W:0]     mul_product,
    input  logic [DATA_W-1:0]   hilo_wr_data,
    input  logic                hi_wr_en,
    input  logic                lo_wr_en,
    output logic [DATA_W-1:0]   hi_out,
    output logic [DATA_W-1:0]   lo_out,
`ifdef MUL_HILO_OVF_EN
    output logic                ovf,
`endif
    output logic                busy,
    output logic                done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    mul_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [DATA_W-1:0]  opa_q,   opa_d;
    logic [DATA_W-1:0]  opb_q,   opb_d;
    logic [DATA_W-1:0]  hi_q,    hi_d;
    logic [DATA_W-1:0]  lo_q,    lo_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               ovf_q,   ovf_d;

    logic               accept_s;
    logic               capture_s;
    logic               unused_prod_msb_s;

    // Bit 64 of the multiplier output carries no information for a signed
    // 32x32 product.
    assign unused_prod_msb_s = mul_product[PROD_W];

    assign accept_s  = (state_q == IDLE) && start;
    assign capture_s = (state_q == SETTLE) && (cnt_q == {CNT_W{1'b0}});

    // State register and all datapath flops.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            opa_q   <= {DATA_W{1'b0}};
            opb_q   <= {DATA_W{1'b0}};
            hi_q    <= {DATA_W{1'b0}};
            lo_q    <= {DATA_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and settle-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output/datapath next values: operand latch, HI/LO load, status flags.
    always_comb begin
        opa_d  = opa_q;
        opb_d  = opb_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = busy_q;
        done_d = 1'b0;
        ovf_d  = ovf_q;

        if (accept_s) begin
            opa_d  = op_a;
            opb_d  = op_b;
            busy_d = 1'b1;
        end else begin
            opa_d = opa_q;
        end

        // Bus writes land only while idle; a write coinciding with start still
        // lands and is later overwritten by the capture.
        if (state_q == IDLE) begin
            if (hi_wr_en) begin
                hi_d = hilo_wr_data;
            end else begin
                hi_d = hi_q;
            end
            if (lo_wr_en) begin
                lo_d = hilo_wr_data;
            end else begin
                lo_d = lo_q;
            end
        end else if (capture_s) begin
            hi_d   = mul_product[PROD_W-1:DATA_W];
            lo_d   = mul_product[DATA_W-1:0];
            done_d = 1'b1;
            busy_d = 1'b0;
            ovf_d  = prod_ovf(mul_product[PROD_W-1:0]);
        end else begin
            hi_d = hi_q;
        end
    end

    assign mul_q  = opa_q;
    assign mul_m  = opb_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign busy   = busy_q;
    assign done   = done_q;

`ifdef MUL_HILO_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf_s;
    assign unused_ovf_s = ovf_q;
`endif

endmodule : mul_hilo_ctrl

// File: tb/tb_mul_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_hilo_ctrl
// Directed bench for mul_hilo_ctrl with SETTLE_CYCLES=2. A behavioural signed
// multiplier feeds mul_product from mul_q/mul_m; a transaction-level model
// predicts every output and is compared on each falling edge, alongside
// hand-computed literal expectations for the key scenarios.
// ---------------------------------------------------------------------------
module tb_mul_hilo_ctrl;

    localparam int S = 2;

    logic        clock = 1'b0;
    logic        clear;
    logic        start = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [31:0] mul_q, mul_m;
    logic [64:0] mul_product;
    logic [31:0] hilo_wr_data = 32'd0;
    logic        hi_wr_en = 1'b0;
    logic        lo_wr_en = 1'b0;
    logic [31:0] hi_out, lo_out;
    logic        busy, done;
`ifdef MUL_HILO_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt;

    mul_hilo_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .op_a         (op_a),
        .op_b         (op_b),
        .mul_q        (mul_q),
        .mul_m        (mul_m),
        .mul_product  (mul_product),
        .hilo_wr_data (hilo_wr_data),
        .hi_wr_en     (hi_wr_en),
        .lo_wr_en     (lo_wr_en),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
`ifdef MUL_HILO_OVF_EN
        .ovf          (ovf),
`endif
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    // Sibling multiplier: signed 32x32 product; bit 64 set to junk.
    longint dut_p;
    assign dut_p       = longint'($signed(mul_q)) * longint'($signed(mul_m));
    assign mul_product = {~dut_p[63], dut_p};

    // Transaction model: remaining edges until capture (0 = idle).
    int          m_left = 0;
    logic [31:0] m_q = 32'd0, m_m = 32'd0, m_hi = 32'd0, m_lo = 32'd0;
    logic        m_done = 1'b0, m_ovf = 1'b0;
    longint      m_p;
    assign m_p = longint'($signed(m_q)) * longint'($signed(m_m));

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            m_left <= 0;
            m_q <= 32'd0; m_m <= 32'd0; m_hi <= 32'd0; m_lo <= 32'd0;
            m_done <= 1'b0; m_ovf <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (hi_wr_en) m_hi <= hilo_wr_data;
                if (lo_wr_en) m_lo <= hilo_wr_data;
                if (start) begin
                    m_q <= op_a; m_m <= op_b; m_left <= S;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= m_p[63:32];
                    m_lo   <= m_p[31:0];
                    m_done <= 1'b1;
                    m_ovf  <= (m_p > 64'sd2147483647) || (m_p < -64'sd2147483648);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        chk("m_busy",  64'(busy),   64'(m_left != 0));
        chk("m_done",  64'(done),   64'(m_done));
        chk("m_hi",    64'(hi_out), 64'(m_hi));
        chk("m_lo",    64'(lo_out), 64'(m_lo));
        chk("m_mul_q", 64'(mul_q),  64'(m_q));
        chk("m_mul_m", 64'(mul_m),  64'(m_m));
`ifdef MUL_HILO_OVF_EN
        chk("m_ovf",   64'(ovf),    64'(m_ovf));
`endif
    end

    // Launch one op at a falling edge; returns at the edge where done shows.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b);
        op_a = a; op_b = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("op_busy1", 64'(busy), 64'd1);
        @(negedge clock);
        chk("op_busy2", 64'(busy), 64'd1);
        chk("op_nodone", 64'(done), 64'd0);
        @(negedge clock);
        chk("op_done", 64'(done), 64'd1);
        chk("op_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        clear = 1'b1;
        #1 clear = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        chk("rst_mul_q", 64'(mul_q), 64'd0);
        clear = 1'b1;
        @(negedge clock);

        // 7 * 6
        do_op(32'd7, 32'd6);
        chk("mul76_hi", 64'(hi_out), 64'h0);
        chk("mul76_lo", 64'(lo_out), 64'h2A);
        @(negedge clock);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_hold_q", 64'(mul_q), 64'd7);

        // -3 * 5
        do_op(32'hFFFF_FFFD, 32'd5);
        chk("neg_hi", 64'(hi_out), 64'hFFFF_FFFF);
        chk("neg_lo", 64'(lo_out), 64'hFFFF_FFF1);
`ifdef MUL_HILO_OVF_EN
        chk("neg_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clock);

        // 0x10000 * 0x10000 = 2^32
        do_op(32'h0001_0000, 32'h0001_0000);
        chk("big_hi", 64'(hi_out), 64'h1);
        chk("big_lo", 64'(lo_out), 64'h0);
`ifdef MUL_HILO_OVF_EN
        chk("big_ovf", 64'(ovf), 64'd1);
`endif
        @(negedge clock);

        // start held high: operands change every cycle, accepted only in IDLE
        done_cnt = 0;
        start = 1'b1;
        op_a = 32'd10; op_b = 32'd1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            if (done) done_cnt++;
            if (k == 1) chk("hold_mul_q", 64'(mul_q), 64'd10);
            if (k == 2) chk("hold_mul_q2", 64'(mul_q), 64'd10);
            if (k == 4) chk("b2b_mul_q", 64'(mul_q), 64'd13);
            if (k == 9) start = 1'b0;
            op_a = 32'(10 + k); op_b = 32'(1 + k);
        end
        chk("b2b_done_cnt", 64'(done_cnt), 64'd3);
        chk("b2b_lo", 64'(lo_out), 64'd112);
        @(negedge clock);

        // bus writes in IDLE
        hilo_wr_data = 32'hDEAD_BEEF; hi_wr_en = 1'b1;
        @(negedge clock);
        hi_wr_en = 1'b0;
        chk("wr_hi", 64'(hi_out), 64'hDEAD_BEEF);
        hilo_wr_data = 32'h1234_5678; hi_wr_en = 1'b1; lo_wr_en = 1'b1;
        @(negedge clock);
        hi_wr_en = 1'b0; lo_wr_en = 1'b0;
        chk("wr_both_hi", 64'(hi_out), 64'h1234_5678);
        chk("wr_both_lo", 64'(lo_out), 64'h1234_5678);

        // writes during busy, including on the capture edge, are ignored
        op_a = 32'd1; op_b = 32'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        hilo_wr_data = 32'hDEAD_BEEF; hi_wr_en = 1'b1; lo_wr_en = 1'b1;
        @(negedge clock);
        chk("busy_wr_hi", 64'(hi_out), 64'h1234_5678);
        @(negedge clock);
        hi_wr_en = 1'b0; lo_wr_en = 1'b0;
        chk("cap_wins_hi", 64'(hi_out), 64'h0);
        chk("cap_wins_lo", 64'(lo_out), 64'h1);

        // start coinciding with a bus write: write lands, capture overwrites
        op_a = 32'd3; op_b = 32'd3; start = 1'b1;
        hilo_wr_data = 32'h0000_0055; hi_wr_en = 1'b1;
        @(negedge clock);
        start = 1'b0; hi_wr_en = 1'b0;
        chk("coinc_hi", 64'(hi_out), 64'h55);
        repeat (2) @(negedge clock);
        chk("coinc_cap_hi", 64'(hi_out), 64'h0);
        chk("coinc_cap_lo", 64'(lo_out), 64'd9);

        // clear one cycle after start aborts the operation
        op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #2 clear = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi_out), 64'd0);
        chk("abort_lo", 64'(lo_out), 64'd0);
        chk("abort_mul_q", 64'(mul_q), 64'd0);
        @(negedge clock);
        clear = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'd0);

        // start sampled on the first edge after clear deasserts
        #2 clear = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        op_a = 32'd4; op_b = 32'd4; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("post_clr_busy", 64'(busy), 64'd1);
        repeat (2) @(negedge clock);
        chk("post_clr_done", 64'(done), 64'd1);
        chk("post_clr_lo", 64'(lo_out), 64'd16);
        repeat (2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mul_hilo_ctrl
